// File: rtl/axi4_if.sv
// AXI4-lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
);
  logic [A-1:0]   awaddr;
  logic [2:0]     awprot;
  logic [I-1:0]   awid;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic [I-1:0]   bid;
  logic           bvalid;
  logic           bready;
  logic [A-1:0]   araddr;
  logic [2:0]     arprot;
  logic [I-1:0]   arid;
  logic           arvalid;
  logic           arready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;
  logic           rvalid;
  logic           rready;

  modport master (
    output awaddr, awprot, awid, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arid, arvalid, rready,
    input  awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rid, rvalid
  );

  modport slave (
    input  awaddr, awprot, awid, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arid, arvalid, rready,
    output awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rid, rvalid
  );
endinterface

// File: rtl/axi4_lite_arbiter_wr.sv
// Two-requester AXI4-lite write arbiter: round-robin grants with a per-tenure
// write quota and an outstanding-write limit; a grant drains its B responses before release.
module axi4_lite_arbiter_wr #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1,
  parameter int D = 4,
  parameter int Q = 4
) (
  input  logic   aclk,
  input  logic   areset,
  axi4_if.slave  axi4_s [2],
  axi4_if.master axi4_m
);
  localparam int CW = $clog2(D) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_reg;
  logic          g_reg;
  logic          p_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    ten_reg;

  logic [A-1:0]   s_awaddr  [2];
  logic [2:0]     s_awprot  [2];
  logic [I-1:0]   s_awid    [2];
  logic           s_awvalid [2];
  logic [8*N-1:0] s_wdata   [2];
  logic [N-1:0]   s_wstrb   [2];
  logic           s_wvalid  [2];
  logic           s_bready  [2];
  logic           s_unused  [2];

  logic active;
  logic cnt_full;
  logic issue_ok;
  logic acc;
  logic b_hs;
  logic gsel;
  logic tenure_end;

  assign active     = (state_reg != IDLE);
  assign cnt_full   = (cnt_reg >= CW'(D));
  assign issue_ok   = (state_reg == ISSUE) & s_awvalid[g_reg] & s_wvalid[g_reg] & ~cnt_full;
  assign acc        = issue_ok & axi4_m.awready & axi4_m.wready;
  assign b_hs       = axi4_m.bvalid & axi4_m.bready;
  // Contention goes to the priority pointer; otherwise the lone requester wins.
  assign gsel       = (s_awvalid[0] & s_awvalid[1]) ? p_reg : s_awvalid[1];
  assign tenure_end = (acc && (ten_reg == 8'(Q - 1))) || !s_awvalid[g_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic sel;
    assign sel = (g_reg == 1'(gi));

    assign s_awaddr[gi]  = axi4_s[gi].awaddr;
    assign s_awprot[gi]  = axi4_s[gi].awprot;
    assign s_awid[gi]    = axi4_s[gi].awid;
    assign s_awvalid[gi] = axi4_s[gi].awvalid;
    assign s_wdata[gi]   = axi4_s[gi].wdata;
    assign s_wstrb[gi]   = axi4_s[gi].wstrb;
    assign s_wvalid[gi]  = axi4_s[gi].wvalid;
    assign s_bready[gi]  = axi4_s[gi].bready;

    // The non-granted requester never sees a ready or a response.
    assign axi4_s[gi].awready = sel & acc;
    assign axi4_s[gi].wready  = sel & acc;
    assign axi4_s[gi].bvalid  = sel & active & axi4_m.bvalid;
    assign axi4_s[gi].bresp   = axi4_m.bresp;
    assign axi4_s[gi].bid     = axi4_m.bid;

    assign axi4_s[gi].arready = 1'b0;
    assign axi4_s[gi].rvalid  = 1'b0;
    assign axi4_s[gi].rdata   = '0;
    assign axi4_s[gi].rresp   = '0;
    assign axi4_s[gi].rid     = '0;

    assign s_unused[gi] = ^{axi4_s[gi].araddr, axi4_s[gi].arprot, axi4_s[gi].arid,
                            axi4_s[gi].arvalid, axi4_s[gi].rready};
  end

  assign axi4_m.awvalid = issue_ok;
  assign axi4_m.wvalid  = issue_ok;
  assign axi4_m.awaddr  = s_awaddr[g_reg];
  assign axi4_m.awprot  = s_awprot[g_reg];
  assign axi4_m.awid    = s_awid[g_reg];
  assign axi4_m.wdata   = s_wdata[g_reg];
  assign axi4_m.wstrb   = s_wstrb[g_reg];
  assign axi4_m.bready  = active & s_bready[g_reg];

  assign axi4_m.araddr  = '0;
  assign axi4_m.arprot  = '0;
  assign axi4_m.arid    = '0;
  assign axi4_m.arvalid = 1'b0;
  assign axi4_m.rready  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{s_unused[0], s_unused[1], axi4_m.arready, axi4_m.rdata,
                       axi4_m.rresp, axi4_m.rid, axi4_m.rvalid};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= IDLE;
      g_reg     <= 1'b0;
      p_reg     <= 1'b0;
      cnt_reg   <= '0;
      ten_reg   <= '0;
    end else begin
      // A B with nothing outstanding is a downstream error; hold at zero.
      if (acc && !b_hs) begin
        cnt_reg <= cnt_reg + CW'(1);
      end else if (b_hs && !acc && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CW'(1);
      end

      case (state_reg)
        IDLE: begin
          if (s_awvalid[0] | s_awvalid[1]) begin
            g_reg     <= gsel;
            p_reg     <= ~gsel;
            ten_reg   <= '0;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc) begin
            ten_reg <= ten_reg + 8'd1;
          end
          if (tenure_end) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_arbiter_wr.sv
// Randomised bench for the two-requester write arbiter: requester and downstream
// models feed a scoreboard that checks routing, ordering, quotas and limits.
module tb_axi4_lite_arbiter_wr;
  localparam int A_P = 32;
  localparam int N_P = 4;
  localparam int I_P = 1;
  localparam int D_P = 4;
  localparam int Q_P = 6;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A_P), .N(N_P), .I(I_P)) s_if [2] ();
  axi4_if #(.A(A_P), .N(N_P), .I(I_P)) m_if ();

  axi4_lite_arbiter_wr #(.A(A_P), .N(N_P), .I(I_P), .D(D_P), .Q(Q_P)) dut (
    .aclk   (aclk),
    .areset (areset),
    .axi4_s (s_if),
    .axi4_m (m_if)
  );

  typedef struct packed {
    logic [A_P-1:0]   addr;
    logic [2:0]       prot;
    logic [I_P-1:0]   id;
    logic [8*N_P-1:0] data;
    logic [N_P-1:0]   strb;
  } wr_t;

  typedef struct packed {
    logic           owner;
    logic [1:0]     resp;
    logic [I_P-1:0] id;
  } bexp_t;

  typedef struct packed {
    logic [1:0]     resp;
    logic [I_P-1:0] id;
  } dsb_t;

  wr_t   exp_q [2][$];
  bexp_t out_q [$];

  int req_left [2];
  int req_rate [2];
  int ds_rate     = 100;
  int bready_rate = 100;
  int b_rate      = 100;
  bit b_hold      = 1'b0;
  bit strict_mode = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int acc_total   = 0;
  int b_total     = 0;

  logic           sv_awvalid [2];
  logic           sv_awready [2];
  logic           sv_wvalid  [2];
  logic           sv_wready  [2];
  logic           sv_bvalid  [2];
  logic           sv_bready  [2];
  logic [1:0]     sv_bresp   [2];
  logic [I_P-1:0] sv_bid     [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign sv_awvalid[gi] = s_if[gi].awvalid;
    assign sv_awready[gi] = s_if[gi].awready;
    assign sv_wvalid[gi]  = s_if[gi].wvalid;
    assign sv_wready[gi]  = s_if[gi].wready;
    assign sv_bvalid[gi]  = s_if[gi].bvalid;
    assign sv_bready[gi]  = s_if[gi].bready;
    assign sv_bresp[gi]   = s_if[gi].bresp;
    assign sv_bid[gi]     = s_if[gi].bid;

    // Requester: holds AW+W until the joint handshake, then optionally issues the next.
    initial begin
      bit  hs;
      wr_t w;
      s_if[gi].awvalid = 1'b0;
      s_if[gi].wvalid  = 1'b0;
      s_if[gi].awaddr  = '0;
      s_if[gi].awprot  = '0;
      s_if[gi].awid    = '0;
      s_if[gi].wdata   = '0;
      s_if[gi].wstrb   = '0;
      s_if[gi].bready  = 1'b0;
      s_if[gi].araddr  = '0;
      s_if[gi].arprot  = '0;
      s_if[gi].arid    = '0;
      s_if[gi].arvalid = 1'b0;
      s_if[gi].rready  = 1'b0;
      forever begin
        @(negedge aclk);
        hs = s_if[gi].awvalid & s_if[gi].awready & s_if[gi].wvalid & s_if[gi].wready;
        @(posedge aclk);
        #1;
        if (hs || !s_if[gi].awvalid) begin
          if (req_left[gi] > 0 && int'($urandom_range(0, 99)) < req_rate[gi]) begin
            w.addr = $urandom;
            w.prot = 3'($urandom);
            w.id   = I_P'($urandom);
            w.data = $urandom;
            w.strb = N_P'($urandom);
            s_if[gi].awaddr  = w.addr;
            s_if[gi].awprot  = w.prot;
            s_if[gi].awid    = w.id;
            s_if[gi].wdata   = w.data;
            s_if[gi].wstrb   = w.strb;
            s_if[gi].awvalid = 1'b1;
            s_if[gi].wvalid  = 1'b1;
            exp_q[gi].push_back(w);
            req_left[gi]--;
          end else begin
            s_if[gi].awvalid = 1'b0;
            s_if[gi].wvalid  = 1'b0;
          end
        end
        s_if[gi].bready = (int'($urandom_range(0, 99)) < bready_rate);
      end
    end
  end

  // Downstream slave: in-order B responses, bresp taken from address bits [5:4].
  initial begin
    bit             aw_hs;
    bit             b_hs;
    bit             rst_s;
    logic [A_P-1:0] a;
    logic [I_P-1:0] id;
    dsb_t           ds_q [$];
    dsb_t           e;
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bvalid  = 1'b0;
    m_if.bresp   = '0;
    m_if.bid     = '0;
    m_if.arready = 1'b0;
    m_if.rdata   = '0;
    m_if.rresp   = '0;
    m_if.rid     = '0;
    m_if.rvalid  = 1'b0;
    forever begin
      @(negedge aclk);
      aw_hs = m_if.awvalid & m_if.awready & m_if.wvalid & m_if.wready;
      b_hs  = m_if.bvalid & m_if.bready;
      rst_s = areset;
      a     = m_if.awaddr;
      id    = m_if.awid;
      @(posedge aclk);
      #1;
      if (rst_s) begin
        ds_q.delete();
        m_if.bvalid = 1'b0;
      end else begin
        if (b_hs) begin
          ds_q.delete(0);
          m_if.bvalid = 1'b0;
        end
        if (aw_hs) begin
          e.resp = a[5:4];
          e.id   = id;
          ds_q.push_back(e);
        end
        if (!m_if.bvalid && ds_q.size() > 0 && !b_hold && int'($urandom_range(0, 99)) < b_rate) begin
          m_if.bvalid = 1'b1;
          m_if.bresp  = ds_q[0].resp;
          m_if.bid    = ds_q[0].id;
        end
      end
      m_if.awready = (int'($urandom_range(0, 99)) < ds_rate);
      m_if.wready  = (int'($urandom_range(0, 99)) < ds_rate);
    end
  end

  // Scoreboard monitor.
  initial begin
    int    size0;
    int    n_hs;
    int    own;
    int    cur_owner;
    int    run_len;
    bit    m_hs;
    bit    hs [2];
    wr_t   w;
    bexp_t e;
    cur_owner = -1;
    run_len   = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        out_q.delete();
        cur_owner = -1;
        run_len   = 0;
        continue;
      end
      size0 = out_q.size();
      m_hs  = m_if.awvalid & m_if.awready & m_if.wvalid & m_if.wready;
      n_hs  = 0;
      for (int k = 0; k < 2; k++) begin
        hs[k] = sv_awvalid[k] & sv_awready[k] & sv_wvalid[k] & sv_wready[k];
        if (hs[k]) n_hs++;
      end

      check("cnt", dut.cnt_reg, size0);
      if (m_if.awvalid | m_if.wvalid) check("aw_w_together", m_if.awvalid, m_if.wvalid);
      if (n_hs != 0 || m_hs) check("acc_pair", {n_hs[1:0], m_hs}, {2'd1, 1'b1});
      if (m_hs) check("cnt_limit", size0 < D_P, 1'b1);
      for (int k = 0; k < 2; k++) begin
        if (sv_awready[k] | sv_wready[k])
          check("ready_qual", {sv_awready[k], sv_wready[k], sv_awvalid[k], sv_wvalid[k], m_hs}, 5'h1f);
      end

      if (size0 > 0) begin
        own = int'(out_q[0].owner);
        if (m_if.bvalid) begin
          check("b_route", {sv_bvalid[own], sv_bvalid[1-own]}, 2'b10);
          check("b_ready", m_if.bready, sv_bready[own]);
          if (m_if.bready) begin
            check("b_payload", {sv_bresp[own], sv_bid[own]}, {out_q[0].resp, out_q[0].id});
            out_q.delete(0);
            b_total++;
          end
        end
      end else if (sv_bvalid[0] | sv_bvalid[1]) begin
        check("b_stray", {sv_bvalid[0], sv_bvalid[1]}, 2'b00);
      end

      for (int k = 0; k < 2; k++) begin
        if (hs[k]) begin
          if (exp_q[k].size() == 0) begin
            check("exp_empty", 1'b1, 1'b0);
            w.addr = m_if.awaddr;
            w.id   = m_if.awid;
          end else begin
            w = exp_q[k].pop_front();
            check("aw_fwd", {m_if.awaddr, m_if.awprot, m_if.awid, m_if.wdata, m_if.wstrb}, w);
          end
          e.owner = 1'(k);
          e.resp  = w.addr[5:4];
          e.id    = w.id;
          out_q.push_back(e);
          acc_total++;
          if (k != cur_owner) begin
            if (strict_mode && cur_owner >= 0) check("tenure_len", run_len, Q_P);
            if (strict_mode && cur_owner < 0) check("first_grant", k, 0);
            cur_owner = k;
            run_len   = 1;
          end else begin
            run_len++;
          end
          if (strict_mode) check("tenure_max", run_len <= Q_P, 1'b1);
        end
      end
    end
  end

  function automatic bit drained();
    return req_left[0] == 0 && req_left[1] == 0 && exp_q[0].size() == 0 &&
           exp_q[1].size() == 0 && out_q.size() == 0;
  endfunction

  task automatic wait_acc(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (acc_total < target && c < budget) begin
      @(posedge aclk);
      c++;
    end
    check(name, acc_total >= target, 1'b1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c;
    c = 0;
    while (!drained() && c < budget) begin
      @(posedge aclk);
      c++;
    end
    check(name, drained(), 1'b1);
    repeat (4) @(posedge aclk);
  endtask

  initial begin
    int base;
    int bb;
    // Both requesters stream continuously out of reset, downstream always ready.
    strict_mode = 1'b1;
    req_rate[0] = 100;
    req_rate[1] = 100;
    req_left[0] = 4 * Q_P;
    req_left[1] = 4 * Q_P;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_ready", {sv_awready[0], sv_awready[1], sv_wready[0], sv_wready[1]}, 4'h0);
    check("rst_down", {m_if.awvalid, m_if.wvalid, m_if.bready, sv_bvalid[0], sv_bvalid[1]}, 5'h0);
    check("rst_cnt", dut.cnt_reg, 0);
    @(posedge aclk);
    #2 areset = 1'b0;
    wait_acc(8 * Q_P, 3000, "strict_timeout");
    wait_drain(2000, "strict_drain");
    strict_mode = 1'b0;

    // Requester 0 alone with B withheld: the outstanding limit stalls the fifth write.
    base        = acc_total;
    b_hold      = 1'b1;
    req_left[0] = 6;
    wait_acc(base + D_P, 500, "limit_fill");
    repeat (8) @(posedge aclk);
    check("limit_count", acc_total, base + D_P);
    @(negedge aclk);
    check("limit_stall", {sv_awvalid[0], sv_awready[0]}, 2'b10);
    bb     = b_total;
    b_hold = 1'b0;
    wait_acc(base + D_P + 1, 500, "limit_release");
    check("limit_b_first", b_total > bb, 1'b1);
    wait_drain(2000, "limit_drain");

    // Reset in ISSUE with three writes outstanding.
    base        = acc_total;
    b_hold      = 1'b1;
    req_left[0] = 5;
    wait_acc(base + 3, 500, "rst_fill");
    ds_rate = 0;
    @(negedge aclk);
    check("rst_pre_cnt", dut.cnt_reg, 3);
    @(posedge aclk);
    #2 areset = 1'b1;
    @(posedge aclk);
    #2 areset = 1'b0;
    @(negedge aclk);
    check("rst_mid_state", int'(dut.state_reg), 0);
    check("rst_mid_cnt", dut.cnt_reg, 0);
    check("rst_mid_ready", {sv_awready[0], sv_awready[1], sv_wready[0], sv_wready[1]}, 4'h0);
    check("rst_mid_down", {m_if.awvalid, m_if.bready}, 2'b00);
    b_hold  = 1'b0;
    ds_rate = 100;
    wait_drain(2000, "rst_drain");

    // Random traffic on both requesters.
    for (int r = 0; r < 8; r++) begin
      req_rate[0] = int'($urandom_range(20, 100));
      req_rate[1] = int'($urandom_range(20, 100));
      ds_rate     = int'($urandom_range(30, 100));
      bready_rate = int'($urandom_range(30, 100));
      b_rate      = int'($urandom_range(20, 100));
      req_left[0] = 25;
      req_left[1] = 25;
      wait_drain(8000, "rand_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
